// File: rtl/gate_seq_pkg.sv
// rtl/gate_seq_pkg.sv - shared types and constants for the gate truth-table sequencer
package gate_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2
    } gate_seq_state_e;

    localparam int NUM_VECTORS = 4;

    // Bit index of each table is {a,b}.
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XOR  = 4'b0110;

endpackage

// File: rtl/gate_tt_sequencer_if.sv
// rtl/gate_tt_sequencer_if.sv - control, result and gate-pin bundle for the sequencer
interface gate_tt_sequencer_if;
    import gate_seq_pkg::*;

    logic                   start;
    logic                   abort;
    logic [NUM_VECTORS-1:0] exp_tt;
    logic                   gate_a;
    logic                   gate_b;
    logic                   gate_y;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [NUM_VECTORS-1:0] obs_tt;
    logic [2:0]             fail_cnt;
    logic [1:0]             first_fail;

    modport master (
        output start, abort, exp_tt, gate_y,
        input  gate_a, gate_b, busy, done, pass, obs_tt, fail_cnt, first_fail
    );

    modport slave (
        input  start, abort, exp_tt, gate_y,
        output gate_a, gate_b, busy, done, pass, obs_tt, fail_cnt, first_fail
    );

endinterface

// File: rtl/gate_settle_timer.sv
// rtl/gate_settle_timer.sv - loadable down-counter timing the settle window of each vector
module gate_settle_timer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expired
);

    generate
        if (SETTLE_CYCLES == 0) begin : g_bypass
            logic unused_inputs;
            assign unused_inputs = &{1'b0, clk, rst_n, load, en};
            assign expired       = 1'b1;
        end else begin : g_count
            localparam int CW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);
            // Loaded with S-1 so the owning state spends exactly S cycles waiting.
            localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE_CYCLES - 1);

            logic [CW-1:0] cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt <= '0;
                end else if (load) begin
                    cnt <= LOAD_VAL;
                end else if (en && (cnt != '0)) begin
                    cnt <= cnt - CW'(1);
                end
            end

            assign expired = (cnt == '0);
        end
    endgenerate

endmodule

// File: rtl/gate_tt_sequencer.sv
// rtl/gate_tt_sequencer.sv - walks a 2-input gate through 00/01/10/11 and checks its truth table
module gate_tt_sequencer
    import gate_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    gate_tt_sequencer_if.slave  bus
);

    localparam logic [1:0] IDLE   = ST_IDLE;
    localparam logic [1:0] SETTLE = ST_SETTLE;
    localparam logic [1:0] SAMPLE = ST_SAMPLE;

    localparam logic [1:0] LAST_IDX   = 2'(NUM_VECTORS - 1);
    // With no settle time each vector goes straight to its sample cycle.
    localparam logic [1:0] WAIT_STATE = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

    logic [1:0] state;
    logic [1:0] idx;
    logic [3:0] exp_l;
    logic       gate_a_r;
    logic       gate_b_r;
    logic       busy_r;
    logic       done_r;
    logic       pass_r;
    logic [3:0] obs_r;
    logic [2:0] fail_r;
    logic [1:0] first_r;

    logic start_ok;
    logic run_abort;
    logic mismatch;
    logic timer_load;
    logic timer_expired;

    assign start_ok   = (state == IDLE) && bus.start && !bus.abort;
    assign run_abort  = (state != IDLE) && bus.abort;
    assign mismatch   = bus.gate_y ^ exp_l[idx];
    assign timer_load = start_ok || ((state == SAMPLE) && !bus.abort && (idx != LAST_IDX));

    gate_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (timer_load),
        .en      (state == SETTLE),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= 2'd0;
            exp_l    <= 4'd0;
            gate_a_r <= 1'b0;
            gate_b_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            pass_r   <= 1'b0;
            obs_r    <= 4'd0;
            fail_r   <= 3'd0;
            first_r  <= 2'd0;
        end else begin
            done_r <= 1'b0;
            if (run_abort) begin
                // Partial obs/fail results stay visible for debug.
                state                <= IDLE;
                idx                  <= 2'd0;
                {gate_a_r, gate_b_r} <= 2'b00;
                busy_r               <= 1'b0;
                pass_r               <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_ok) begin
                            exp_l                <= bus.exp_tt;
                            obs_r                <= 4'd0;
                            fail_r               <= 3'd0;
                            first_r              <= 2'd0;
                            pass_r               <= 1'b0;
                            idx                  <= 2'd0;
                            {gate_a_r, gate_b_r} <= 2'b00;
                            busy_r               <= 1'b1;
                            state                <= WAIT_STATE;
                        end
                    end
                    SETTLE: begin
                        if (timer_expired) begin
                            state <= SAMPLE;
                        end
                    end
                    SAMPLE: begin
                        obs_r[idx] <= bus.gate_y;
                        if (mismatch) begin
                            fail_r <= fail_r + 3'd1;
                            if (fail_r == 3'd0) begin
                                first_r <= idx;
                            end
                        end
                        if (idx != LAST_IDX) begin
                            idx                  <= idx + 2'd1;
                            {gate_a_r, gate_b_r} <= idx + 2'd1;
                            state                <= WAIT_STATE;
                        end else begin
                            idx                  <= 2'd0;
                            {gate_a_r, gate_b_r} <= 2'b00;
                            busy_r               <= 1'b0;
                            done_r               <= 1'b1;
                            pass_r               <= (fail_r == 3'd0) && !mismatch;
                            state                <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.gate_a     = gate_a_r;
    assign bus.gate_b     = gate_b_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.pass       = pass_r;
    assign bus.obs_tt     = obs_r;
    assign bus.fail_cnt   = fail_r;
    assign bus.first_fail = first_r;

endmodule
